// File: rtl/digit_serial_arith_unit.sv
// Digit-serial four-function arithmetic unit: A plus {0, B, ~B, all-ones} plus cin,
// evaluated DIGIT bits per clock through a registered carry.
module digit_serial_arith_unit #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             s1,
  input  logic             s0,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             o_dbg_state
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_s;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;
  logic             r_done;

  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [DIGIT-1:0] w_a_sl;
  logic [DIGIT-1:0] w_b_sl;
  logic [DIGIT:0]   w_sum;
  logic             w_last;
  logic             w_accept;
  logic             w_ovf;

  // Handshake: start is a request accepted only on an edge where busy=0; busy
  // stays high for N cycles and done pulses for one cycle with the result.
  assign w_accept = (r_state == ST_IDLE) && start;
  assign w_last   = (r_cnt == CW'(N - 1));

  always_comb begin
    w_b_eff = '0;
    case ({s1, s0})
      2'b00:   w_b_eff = '0;
      2'b01:   w_b_eff = b;
      2'b10:   w_b_eff = ~b;
      default: w_b_eff = '1;
    endcase
  end

  assign w_a_sl = r_a[r_cnt*DIGIT +: DIGIT];
  assign w_b_sl = r_b[r_cnt*DIGIT +: DIGIT];
  assign w_sum  = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{DIGIT{1'b0}}, r_carry};

  // Carry into the MSB is recovered as a^b^sum at that bit, so DIGIT=1 needs no special case.
  assign w_ovf = w_a_sl[DIGIT-1] ^ w_b_sl[DIGIT-1] ^ w_sum[DIGIT-1] ^ w_sum[DIGIT];

  always_comb begin
    w_acc_nxt = r_acc;
    w_acc_nxt[r_cnt*DIGIT +: DIGIT] = w_sum[DIGIT-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start)  w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_s     <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_a     <= a;
        r_b     <= w_b_eff;
        r_acc   <= '0;
        r_cnt   <= '0;
        r_carry <= cin;
      end else if (r_state == ST_RUN) begin
        r_acc   <= w_acc_nxt;
        r_carry <= w_sum[DIGIT];
        r_cnt   <= r_cnt + 1'b1;
        if (w_last) begin
          r_s    <= w_acc_nxt;
          r_cout <= w_sum[DIGIT];
          r_ovf  <= w_ovf;
          r_zero <= (w_acc_nxt == '0);
          r_done <= 1'b1;
        end
      end
    end
  end

  assign busy        = (r_state == ST_RUN);
  assign done        = r_done;
  assign s           = r_s;
  assign cout        = r_cout;
  assign ovf         = r_ovf;
  assign zero        = r_zero;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_digit_serial_arith_unit.sv
// Directed bench for digit_serial_arith_unit (WIDTH=8, DIGIT=2): result, flags,
// latency, handshake and abort behaviour against hand-computed values.
module tb_digit_serial_arith_unit;

  localparam int WIDTH = 8;
  localparam int DIGIT = 2;
  localparam int N     = WIDTH / DIGIT;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             s1 = 1'b0;
  logic             s0 = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             dbg_state;

  int checks   = 0;
  int failures = 0;

  digit_serial_arith_unit #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk(clk), .rst(rst), .start(start), .s1(s1), .s0(s0),
    .a(a), .b(b), .cin(cin), .busy(busy), .done(done),
    .s(s), .cout(cout), .ovf(ovf), .zero(zero), .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // driver: apply an operation at a negedge, pulse start for one edge, then scramble inputs
  task automatic start_op(input logic [1:0] mode, input logic [WIDTH-1:0] va,
                          input logic [WIDTH-1:0] vb, input logic vcin);
    {s1, s0} = mode;
    a        = va;
    b        = vb;
    cin      = vcin;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    a        = WIDTH'($urandom_range(0, 255));
    b        = WIDTH'($urandom_range(0, 255));
    cin      = 1'($urandom_range(0, 1));
    {s1, s0} = 2'($urandom_range(0, 3));
  endtask

  // waits for done; counts cycles and busy samples; optionally checks s holds hold_val
  task automatic wait_done(input string tag, output int cycles, output int busy_cnt,
                           input bit chk_hold, input logic [WIDTH-1:0] hold_val);
    cycles   = 0;
    busy_cnt = 0;
    while (!done && cycles < 30) begin
      if (busy) busy_cnt++;
      if (chk_hold && s !== hold_val) chk({tag, "_hold"}, 32'(s), 32'(hold_val));
      @(negedge clk);
      cycles++;
    end
    if (!done) chk({tag, "_timeout"}, 32'(done), 32'd1);
  endtask

  task automatic chk_res(input string tag, input logic [WIDTH-1:0] es,
                         input logic ec, input logic eo, input logic ez);
    chk({tag, "_s"},    32'(s),    32'(es));
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
    chk({tag, "_ovf"},  32'(ovf),  32'(eo));
    chk({tag, "_zero"}, 32'(zero), 32'(ez));
  endtask

  // scoreboard of expected results, consumed in order
  logic [WIDTH+2:0] exp_q[$];

  task automatic run_and_check(input string tag, input logic [1:0] mode,
                               input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                               input logic vcin);
    int cyc;
    int bc;
    logic [WIDTH+2:0] e;
    start_op(mode, va, vb, vcin);
    wait_done(tag, cyc, bc, 1'b0, '0);
    e = exp_q.pop_front();
    chk({tag, "_lat"}, 32'(cyc), 32'(N));
    chk_res(tag, e[WIDTH+2:3], e[2], e[1], e[0]);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int cyc;
    int bc;
    int ndone;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk_res("rst", 8'h00, 1'b0, 1'b0, 1'b0);

    // 1: add with busy length
    @(negedge clk);
    start_op(2'b01, 8'h3C, 8'h0F, 1'b0);
    wait_done("add", cyc, bc, 1'b0, '0);
    chk("add_lat", 32'(cyc), 32'd4);
    chk("add_busy_cycles", 32'(bc), 32'd4);
    chk("add_busy_at_done", 32'(busy), 32'd0);
    chk_res("add", 8'h4B, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("add_done_pulse", 32'(done), 32'd0);

    // 2-4: {s, cout, ovf, zero}
    exp_q.push_back({8'hFE, 1'b0, 1'b0, 1'b0});
    run_and_check("sub_neg", 2'b10, 8'h05, 8'h07, 1'b1);
    exp_q.push_back({8'h02, 1'b1, 1'b0, 1'b0});
    run_and_check("sub_pos", 2'b10, 8'h07, 8'h05, 1'b1);
    exp_q.push_back({8'h80, 1'b0, 1'b1, 1'b0});
    run_and_check("add_ovf", 2'b01, 8'h7F, 8'h01, 1'b0);
    exp_q.push_back({8'h00, 1'b1, 1'b0, 1'b1});
    run_and_check("add_wrap", 2'b01, 8'hFF, 8'h01, 1'b0);
    exp_q.push_back({8'hFF, 1'b0, 1'b0, 1'b0});
    run_and_check("dec_zero", 2'b11, 8'h00, 8'h5A, 1'b0);
    exp_q.push_back({8'h0F, 1'b1, 1'b0, 1'b0});
    run_and_check("dec_10", 2'b11, 8'h10, 8'hA5, 1'b0);
    exp_q.push_back({8'h00, 1'b1, 1'b0, 1'b1});
    run_and_check("inc_ff", 2'b00, 8'hFF, 8'h33, 1'b1);

    // 5: start while busy ignored, then start in the done cycle
    start_op(2'b01, 8'h01, 8'h01, 1'b0);
    a = 8'hAA;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("hs1", cyc, bc, 1'b0, '0);
    chk("hs1_lat", 32'(cyc + 1), 32'd4);
    chk_res("hs1", 8'h02, 1'b0, 1'b0, 1'b0);
    start_op(2'b01, 8'h10, 8'h20, 1'b0);
    chk("hs2_busy", 32'(busy), 32'd1);
    wait_done("hs2", cyc, bc, 1'b1, 8'h02);
    chk("hs2_gap", 32'(cyc + 1), 32'd5);
    chk_res("hs2", 8'h30, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    // 6: abort mid-run
    start_op(2'b01, 8'h3C, 8'h0F, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk_res("abort", 8'h00, 1'b0, 1'b0, 1'b0);
    ndone = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    chk("abort_s_held", 32'(s), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/digit_serial_arith_unit.md
Name: digit_serial_arith_unit

Overview:
Parametrised, multi-cycle successor to the team's 4-bit mode-controlled parallel adder. It implements the same four-function arithmetic circuit (transfer/increment, add, subtract, decrement), selected by s1,s0, at any WIDTH. The datapath is processed DIGIT bits per clock through a registered carry, which trades latency for a narrow adder slice. A start/busy/done handshake lets a controller or test sequencer issue operations back-to-back.

Parameters:
WIDTH, 8, operand/result width in bits; must be an integer multiple of DIGIT.
DIGIT, 2, bits processed per clock; N = WIDTH/DIGIT cycles per operation.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only when busy=0
s1  input  1  mode select, high bit
s0  input  1  mode select, low bit
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in
busy  output  1  operation in progress
done  output  1  one-cycle completion pulse
s  output  WIDTH  result
cout  output  1  carry out of MSB
ovf  output  1  signed overflow
zero  output  1  high when s == 0

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst=1 at an edge, overrides everything): state=IDLE, busy=0, done=0, s=0, cout=0, ovf=0, zero=0. Digit counter, carry register and operand shadows are cleared.
- Effective B operand per mode {s1,s0}:
  - 00: all zeros, giving A+cin (transfer/increment).
  - 01: b, giving A+B+cin.
  - 10: ~b, giving A-B when cin=1, or A-B-1 when cin=0.
  - 11: all ones, giving A-1+cin (decrement/transfer).
- Arithmetic is modulo 2^WIDTH.
- cout = carry out of bit WIDTH-1. In subtract mode with cin=1, cout=1 means no borrow.
- ovf = carry into MSB XOR carry out of MSB.
- zero is computed from the final result.
- FSM states:
  - IDLE:
    - If start=1 at an edge: latch a, effective B and mode. Load the carry register with cin. Clear the counter. Go to RUN. busy goes 1 at that edge.
  - RUN:
    - Each edge adds DIGIT-bit slice k of A and effective B plus the carry register.
    - The sum slice is written into the internal accumulator at bit position k*DIGIT.
    - The carry register is updated and the counter is incremented.
    - At the edge processing slice N-1:
      - Transfer the accumulator to s and update cout, ovf and zero.
      - Set done=1, busy=0 and return to IDLE.
- Latency: start sampled at edge T, so done=1 and s are valid in the cycle after edge T+N. For WIDTH=8 and DIGIT=2, done follows edge T+4.
- done is high exactly one cycle.
- s, cout, ovf and zero hold their values until the next completion or reset. They never show partial results.
- Inputs a, b, cin, s1 and s0 are don't-care after the start edge; changing them mid-operation has no effect.
- start while busy=1 is ignored and is not queued.
- start in the done cycle (busy=0) is accepted, so back-to-back throughput is one operation per N+1 cycles.
- Reset mid-RUN aborts the operation: no done pulse, and outputs clear as listed above.
- DIGIT=WIDTH is legal: N=1, and done follows edge T+1.

Test Plan:
Configuration for all scenarios is WIDTH=8, DIGIT=2.
1. Add, mode 01: a=0x3C, b=0x0F, cin=0, start pulse -> done exactly 4 edges later; s=0x4B, cout=0, ovf=0, zero=0. busy=1 for 4 cycles.
2. Subtract, mode 10, cin=1:
   - a=0x05, b=0x07 -> s=0xFE, cout=0.
   - Then a=0x07, b=0x05 -> s=0x02, cout=1. ovf=0 in both.
3. Add flags, mode 01, cin=0:
   - a=0x7F, b=0x01 -> s=0x80, ovf=1, cout=0.
   - a=0xFF, b=0x01 -> s=0x00, cout=1, zero=1, ovf=0.
4. Decrement and increment:
   - Mode 11, cin=0, a=0x00 -> s=0xFF, cout=0.
   - Mode 11, cin=0, a=0x10 -> s=0x0F, cout=1.
   - Mode 00, cin=1, a=0xFF -> s=0x00, cout=1, zero=1.
5. Handshake:
   - First op: mode 01, a=0x01, b=0x01. While busy, pulse start with a=0xAA -> ignored; result 0x02.
   - Assert start in the done cycle (mode 01, a=0x10, b=0x20) -> second done 5 cycles after the first; s=0x30. s holds 0x02 in between.
6. Abort: start add a=0x3C, b=0x0F, then rst=1 for one edge 2 cycles in -> busy=0, done=0, s=0, flags 0. No done pulse appears afterwards.
